// File: rtl/sha3_pad_blk_if.sv
// ---------------------------------------------------------------------------
// sha3_pad_blk_if
// Bundles the signals around the SHA3 padding/block assembler:
//   message stream : s_data, s_bytes, s_last, s_valid (to block), s_ready (from block)
//   core side      : blk, blk_valid, blk_more (to core `in`, `in_valid`, `more`)
//                    core_hash_next, core_out_valid (completion pulses from core)
// The master modport is the environment (message source plus sponge core);
// the slave modport is the padding block itself.
// ---------------------------------------------------------------------------
interface sha3_pad_blk_if #(
   parameter int BLK_W = 1088
);
   logic [63:0]      s_data;
   logic [3:0]       s_bytes;
   logic             s_last;
   logic             s_valid;
   logic             s_ready;
   logic [BLK_W-1:0] blk;
   logic             blk_valid;
   logic             blk_more;
   logic             core_hash_next;
   logic             core_out_valid;

   modport master (
      output s_data, s_bytes, s_last, s_valid, core_hash_next, core_out_valid,
      input  s_ready, blk, blk_valid, blk_more
   );

   modport slave (
      input  s_data, s_bytes, s_last, s_valid, core_hash_next, core_out_valid,
      output s_ready, blk, blk_valid, blk_more
   );
endinterface

// File: rtl/sha3_pad_blk.sv
// ---------------------------------------------------------------------------
// sha3_pad_blk
// Feeds a SHA3-256 sponge core. Collects 64-bit message words into a rate
// block, applies pad10*1 with the domain-separation byte, and issues each
// block to the core as a one-cycle blk_valid with a held blk_more flag.
// The next block is assembled while the core absorbs the previous one.
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sha3_pad_blk_if.slave (message stream in, block out, core pulses in)
//
// Buffer layout: asm_q holds message byte k at asm_q[8k+7:8k]. The core wants
// byte k bit b at blk[BLK_W-1-8k-b], which is exactly a full bit reversal of
// asm_q, so the reversal is applied once when the block is issued.
// ---------------------------------------------------------------------------
module sha3_pad_blk #(
   parameter logic [7:0] DSBYTE     = 8'h06,
   parameter int         RATE_BYTES = 136
) (
   input  logic            clk,
   input  logic            rst_n,
   sha3_pad_blk_if.slave   bus
);
   localparam int         BLK_W     = 8 * RATE_BYTES;
   localparam logic [4:0] LAST_WIDX = 5'(RATE_BYTES / 8 - 1);
   localparam logic [7:0] RATE_P    = 8'(RATE_BYTES);

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_FULL   = 2'd1,
      ST_PADBLK = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [4:0]       widx_q, widx_d;
   logic [BLK_W-1:0] asm_q, asm_d;
   logic [BLK_W-1:0] blk_q, blk_d;
   logic             blk_valid_q, blk_valid_d;
   logic             blk_more_q, blk_more_d;
   logic             core_busy_q, core_busy_d;
   logic             pad_pending_q, pad_pending_d;
   logic             full_more_q, full_more_d;
   logic             s_ready_q;

   logic [3:0]       nbytes_s;
   logic [63:0]      word_s;
   logic [7:0]       p_s;
   logic [10:0]      word_base_s;
   logic [10:0]      pad_base_s;
   logic             accept_s;

   // Reverse the whole vector: assembly byte order to core bit order.
   function automatic logic [BLK_W-1:0] bit_rev(input logic [BLK_W-1:0] v);
      logic [BLK_W-1:0] r;
      for (int i = 0; i < BLK_W; i++) begin
         r[BLK_W-1-i] = v[i];
      end
      return r;
   endfunction

   // Effective byte count of the incoming word (non-final words are always full).
   always_comb begin
      if (!bus.s_last) begin
         nbytes_s = 4'd8;
      end else if (bus.s_bytes > 4'd8) begin
         nbytes_s = 4'd8;
      end else begin
         nbytes_s = bus.s_bytes;
      end
   end

   // Zero the bytes of the incoming word beyond its valid count.
   always_comb begin
      word_s = 64'h0;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < nbytes_s) begin
            word_s[8*i +: 8] = bus.s_data[8*i +: 8];
         end else begin
            word_s[8*i +: 8] = 8'h00;
         end
      end
   end

   assign accept_s    = bus.s_valid & s_ready_q;
   assign p_s         = {widx_q, 3'b000} + {4'b0000, nbytes_s};
   assign word_base_s = {widx_q, 6'b000000};
   assign pad_base_s  = {p_s, 3'b000};

   // Next-state and datapath decisions for fill / issue / pad-only block.
   always_comb begin
      state_d       = state_q;
      widx_d        = widx_q;
      asm_d         = asm_q;
      blk_d         = blk_q;
      blk_valid_d   = 1'b0;
      blk_more_d    = blk_more_q;
      pad_pending_d = pad_pending_q;
      full_more_d   = full_more_q;

      // A completion pulse only matters while the core is marked busy.
      if (core_busy_q && (bus.core_hash_next || bus.core_out_valid)) begin
         core_busy_d = 1'b0;
      end else begin
         core_busy_d = core_busy_q;
      end

      case (state_q)
         ST_FILL: begin
            if (accept_s) begin
               asm_d[word_base_s +: 64] = word_s;
               if (bus.s_last) begin
                  widx_d  = 5'd0;
                  state_d = ST_FULL;
                  if (p_s == RATE_P) begin
                     // Message ends exactly on a block boundary: padding goes
                     // into a separate block built after this one issues.
                     full_more_d   = 1'b1;
                     pad_pending_d = 1'b1;
                  end else begin
                     // XOR handles p = RATE_BYTES-1, where both pad bytes coincide.
                     asm_d[pad_base_s +: 8] = asm_d[pad_base_s +: 8] ^ DSBYTE;
                     asm_d[BLK_W-8 +: 8]    = asm_d[BLK_W-8 +: 8] ^ 8'h80;
                     full_more_d            = 1'b0;
                  end
               end else if (widx_q == LAST_WIDX) begin
                  widx_d      = 5'd0;
                  full_more_d = 1'b1;
                  state_d     = ST_FULL;
               end else begin
                  widx_d = widx_q + 5'd1;
               end
            end else begin
               state_d = ST_FILL;
            end
         end

         ST_FULL: begin
            // core_busy_q is registered, so issue lands at least one cycle
            // after the completion pulse that cleared it.
            if (!core_busy_q) begin
               blk_d       = bit_rev(asm_q);
               blk_more_d  = full_more_q;
               blk_valid_d = 1'b1;
               core_busy_d = 1'b1;
               asm_d       = '0;
               if (pad_pending_q) begin
                  state_d = ST_PADBLK;
               end else begin
                  state_d = ST_FILL;
               end
            end else begin
               state_d = ST_FULL;
            end
         end

         ST_PADBLK: begin
            asm_d               = '0;
            asm_d[7:0]          = DSBYTE;
            asm_d[BLK_W-1 -: 8] = 8'h80;
            full_more_d         = 1'b0;
            pad_pending_d       = 1'b0;
            state_d             = ST_FULL;
         end

         default: begin
            state_d = ST_FILL;
            widx_d  = 5'd0;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial message.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_FILL;
         widx_q        <= 5'd0;
         asm_q         <= '0;
         blk_q         <= '0;
         blk_valid_q   <= 1'b0;
         blk_more_q    <= 1'b0;
         core_busy_q   <= 1'b0;
         pad_pending_q <= 1'b0;
         full_more_q   <= 1'b0;
         s_ready_q     <= 1'b1;
      end else begin
         state_q       <= state_d;
         widx_q        <= widx_d;
         asm_q         <= asm_d;
         blk_q         <= blk_d;
         blk_valid_q   <= blk_valid_d;
         blk_more_q    <= blk_more_d;
         core_busy_q   <= core_busy_d;
         pad_pending_q <= pad_pending_d;
         full_more_q   <= full_more_d;
         s_ready_q     <= (state_d == ST_FILL);
      end
   end

   assign bus.s_ready   = s_ready_q;
   assign bus.blk       = blk_q;
   assign bus.blk_valid = blk_valid_q;
   assign bus.blk_more  = blk_more_q;
endmodule
